// File: rtl/comp4_sweep_driver.sv
// Exhaustive x/y sweep driver and checker for a magnitude comparator (gt/eq/lt flags).
// Optional: define COMP4_SWEEP_HALT_EN to stop the sweep at the first failing vector.
module comp4_sweep_driver #(
   parameter int WIDTH      = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   x_out,
   output logic [WIDTH-1:0]   y_out,
   input  logic               gt_in,
   input  logic               eq_in,
   input  logic               lt_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH:0]   err_cnt,
   output logic [WIDTH-1:0]   fail_x,
   output logic [WIDTH-1:0]   fail_y,
   output logic               pass_led,
   output logic               fail_led
);

   localparam int IW = 2 * WIDTH;
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
`ifdef COMP4_SWEEP_HALT_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW:0]       err_q, err_d;
   logic [WIDTH-1:0]  fx_q, fx_d, fy_q, fy_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              pass_q, fled_q;

   logic [WIDTH-1:0]  cur_x, cur_y;
   logic              mismatch;

   assign cur_x    = idx_q[IW-1:WIDTH];
   assign cur_y    = idx_q[WIDTH-1:0];
   assign mismatch = ({gt_in, eq_in, lt_in} != {cur_x > cur_y, cur_x == cur_y, cur_x < cur_y});

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fx_d    = '0;
               fy_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            // the entry cycle counts as the first settle cycle
            if (cnt_q == CW'(SETTLE_CYC - 1)) state_d = S_CHECK;
            else                             cnt_d   = cnt_q + 1'b1;
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (err_q == '0) begin
                  fx_d = cur_x;
                  fy_d = cur_y;
               end
            end
            if ((mismatch && HALT) || (idx_q == '1)) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + 1'b1;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fx_q    <= '0;
         fy_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fled_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= done_d && (err_d == '0);
         fled_q  <= (err_d != '0);
      end
   end

   assign x_out    = cur_x;
   assign y_out    = cur_y;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err_cnt  = err_q;
   assign fail_x   = fx_q;
   assign fail_y   = fy_q;
   assign pass_led = pass_q;
   assign fail_led = fled_q;

endmodule
